// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM arbiter slice.
// FSM states and requester port indices.
package bram_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with last-served pointer.
// Ports: clk, rst_n, req[1:0] in; gnt[1:0] out (one-hot or zero).
import bram_arb_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 when B was the last port served
  logic last_b;

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_A] && req[PORT_B]) begin
      if (last_b) gnt[PORT_A] = 1'b1;
      else        gnt[PORT_B] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (|gnt) begin
      last_b <= gnt[PORT_B];
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between ports A and B, plus a clear sweep.
// Ports: a_*/b_* requesters, clr_* sequencer, mem_* to/from BRAM.
import bram_arb_pkg::*;

module bram_arbiter #(
  parameter int WIDTH  = 8,
  parameter int LEN    = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  input  logic              clr_start,
  input  logic [WIDTH-1:0]  clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_din,
  output logic              mem_we,
  input  logic [WIDTH-1:0]  mem_dout
);

  localparam logic [ADDR_W:0] CNT_LAST =
    (ADDR_W+1)'(LEN-1);
  localparam logic [ADDR_W:0] CNT_ONE =
    (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W:0]   cnt;
  logic [WIDTH-1:0]  fill;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              a_rv_q;
  logic              b_rv_q;
  logic              idle_ok;
  logic [1:0]        req;
  logic [1:0]        gnt;

  // A starting clear owns the cycle, so no port may win it
  assign idle_ok = rst_n && (state == ST_IDLE) && !clr_start;
  assign req     = {b_req, a_req} & {2{idle_ok}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign a_gnt    = gnt[PORT_A];
  assign b_gnt    = gnt[PORT_B];
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign a_rdata  = mem_dout;
  assign b_rdata  = mem_dout;
  assign clr_busy = (state == ST_CLEAR);
  assign clr_done = done_q;

  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    mem_addr = addr_q;
    mem_din  = '0;
    unique case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nx = ST_CLEAR;
        end else if (gnt[PORT_A]) begin
          mem_we   = a_we;
          mem_addr = a_addr;
          mem_din  = a_wdata;
        end else if (gnt[PORT_B]) begin
          mem_we   = b_we;
          mem_addr = b_addr;
          mem_din  = b_wdata;
        end
      end
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt[ADDR_W-1:0];
        mem_din  = fill;
        if (cnt == CNT_LAST) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (!rst_n) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      fill   <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
    end else begin
      state  <= state_nx;
      addr_q <= mem_addr;
      done_q <= (state == ST_CLEAR) &&
                (cnt == CNT_LAST);
      a_rv_q <= gnt[PORT_A] & ~a_we;
      b_rv_q <= gnt[PORT_B] & ~b_we;
      if ((state == ST_IDLE) && clr_start) begin
        cnt  <= '0;
        fill <= clr_data;
      end else if (state == ST_CLEAR) begin
        cnt  <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural BRAM.
// Reference: expected memory image, last-served flag, read queue.
module tb_bram_arbiter;

  localparam int LEN = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [7:0] b_addr, b_wdata, b_rdata;
  logic       clr_start, clr_busy, clr_done;
  logic [7:0] clr_data;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic       mem_we;

  logic [7:0] bram    [LEN];
  logic [7:0] ref_mem [LEN];
  bit         last_b;
  int         total = 0;
  int         bad   = 0;

  bram_arbiter #(.WIDTH(8), .LEN(LEN), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_gnt(a_gnt),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .clr_data(clr_data),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // single-port BRAM, read-first, 1-cycle latency
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'd3;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'd4;
    a_wdata = 8'hEE; b_wdata = 8'hDD;
    clr_start = 1'b0; clr_data = 8'h00;
    step(); step(); #1;
    total++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      bad++;
      $display("FAIL rst_gnt got=%b want=00",
               {a_gnt, b_gnt});
    end
    total++;
    if (mem_we !== 1'b0) begin
      bad++;
      $display("FAIL rst_we got=%b want=0", mem_we);
    end
    total++;
    if ({clr_busy, clr_done} !== 2'b00) begin
      bad++;
      $display("FAIL rst_clr got=%b want=00",
               {clr_busy, clr_done});
    end
    a_req = 1'b0; b_req = 1'b0;
    a_we = 1'b0; b_we = 1'b0;
    rst_n = 1'b1;
    last_b = 1'b1;
    step(); #1;
    total++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      bad++;
      $display("FAIL rst_rv got=%b want=00",
               {a_rvalid, b_rvalid});
    end
    step();
  endtask

  task automatic test_single_read();
    bram[5] = 8'h41; ref_mem[5] = 8'h41;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd5;
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_we, mem_addr} !==
        {1'b1, 1'b0, 1'b0, 8'd5}) begin
      bad++;
      $display("FAIL rd1_gnt got=%b%b%b/%0h want=100/5",
               a_gnt, b_gnt, mem_we, mem_addr);
    end
    last_b = 1'b0;
    step();
    a_req = 1'b0;
    #1;
    total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'h41 ||
        b_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rd1_data got=%b/%h/%b want=1/41/0",
               a_rvalid, a_rdata, b_rvalid);
    end
    step(); #1;
    total++;
    if (a_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rd1_once got=%b want=0", a_rvalid);
    end
    step();
  endtask

  task automatic test_alternate();
    bit         eav, ebv, ga, gb;
    logic [7:0] ead, ebd;
    logic [7:0] ra, rb;
    ra = 8'($urandom); rb = 8'($urandom);
    eav = 1'b0; ebv = 1'b0; ead = '0; ebd = '0;
    a_req = 1'b1; a_we = 1'b0; a_addr = ra;
    b_req = 1'b1; b_we = 1'b0; b_addr = rb;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (a_rvalid !== eav || b_rvalid !== ebv ||
          (eav && a_rdata !== ead) ||
          (ebv && b_rdata !== ebd)) begin
        bad++;
        $display("FAIL alt_rv c%0d got=%b%b/%h want=%b%b/%h",
                 i, a_rvalid, b_rvalid, a_rdata,
                 eav, ebv, eav ? ead : ebd);
      end
      ga = last_b; gb = !last_b;
      total++;
      if (a_gnt !== ga || b_gnt !== gb) begin
        bad++;
        $display("FAIL alt_gnt c%0d got=%b%b want=%b%b",
                 i, a_gnt, b_gnt, ga, gb);
      end
      last_b = gb;
      eav = ga; ead = ref_mem[ra];
      ebv = gb; ebd = ref_mem[rb];
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    #1;
    total++;
    if (a_rvalid !== eav || b_rvalid !== ebv ||
        (eav && a_rdata !== ead) ||
        (ebv && b_rdata !== ebd)) begin
      bad++;
      $display("FAIL alt_last got=%b%b want=%b%b",
               a_rvalid, b_rvalid, eav, ebv);
    end
    step();
  endtask

  task automatic test_write_read();
    a_req = 1'b1; a_we = 1'b1;
    a_addr = 8'd10; a_wdata = 8'h5A;
    #1;
    total++;
    if ({a_gnt, mem_we, mem_addr, mem_din} !==
        {1'b1, 1'b1, 8'd10, 8'h5A}) begin
      bad++;
      $display("FAIL wr_issue got=%b%b/%h/%h want=11/0a/5a",
               a_gnt, mem_we, mem_addr, mem_din);
    end
    ref_mem[10] = 8'h5A;
    last_b = 1'b0;
    step();
    a_we = 1'b0; a_wdata = 8'h00;
    #1;
    total++;
    if (a_rvalid !== 1'b0 || a_gnt !== 1'b1) begin
      bad++;
      $display("FAIL wr_norv got=%b/%b want=0/1",
               a_rvalid, a_gnt);
    end
    step();
    a_req = 1'b0;
    #1;
    total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'h5A) begin
      bad++;
      $display("FAIL raw got=%b/%h want=1/5a",
               a_rvalid, a_rdata);
    end
    step();
  endtask

  task automatic test_clear(input logic [7:0] fill,
                            input bit same);
    int n;
    int errs;
    bit ok;
    clr_start = 1'b1; clr_data = fill;
    a_req = same; a_we = 1'b0; a_addr = 8'd255;
    #1;
    total++;
    if ({a_gnt, b_gnt, mem_we} !== 3'b000) begin
      bad++;
      $display("FAIL clr_win got=%b%b%b want=000",
               a_gnt, b_gnt, mem_we);
    end
    step();
    clr_start = 1'b0; clr_data = ~fill;
    a_req = 1'b1;
    n = 0; ok = 1'b1;
    while (n < 300) begin
      #1;
      if (!clr_busy) break;
      if (mem_we !== 1'b1 || mem_addr !== 8'(n) ||
          mem_din !== fill || a_gnt !== 1'b0 ||
          clr_done !== 1'b0) ok = 1'b0;
      n++;
      // a second start mid-sweep must be ignored
      clr_start = (n == 50);
      step();
    end
    clr_start = 1'b0;
    total++;
    if (!ok || n != LEN) begin
      bad++;
      $display("FAIL clr_sweep got=%0d/%b want=%0d/1",
               n, ok, LEN);
    end
    total++;
    if (clr_done !== 1'b1 || a_gnt !== 1'b1 ||
        mem_addr !== 8'd255) begin
      bad++;
      $display("FAIL clr_end got=%b%b/%h want=11/ff",
               clr_done, a_gnt, mem_addr);
    end
    for (int i = 0; i < LEN; i++) ref_mem[i] = fill;
    last_b = 1'b0;
    step();
    a_req = 1'b0;
    #1;
    total++;
    if (clr_done !== 1'b0 || a_rvalid !== 1'b1 ||
        a_rdata !== fill) begin
      bad++;
      $display("FAIL clr_rd got=%b%b/%h want=01/%h",
               clr_done, a_rvalid, a_rdata, fill);
    end
    errs = 0;
    for (int i = 0; i < LEN; i++)
      if (bram[i] !== ref_mem[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL clr_image got=%0d want=0 bad words",
               errs);
    end
    step();
  endtask

  task automatic test_clear_abort();
    int n;
    int errs;
    for (int i = 0; i < LEN; i++) begin
      bram[i] = 8'($urandom);
      ref_mem[i] = bram[i];
    end
    clr_start = 1'b1; clr_data = 8'hC3;
    step();
    clr_start = 1'b0;
    #1;
    n = 0;
    while (mem_addr !== 8'd100 && n < 300) begin
      step(); #1; n++;
    end
    total++;
    if (n >= 300 || clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_reach got=%0d/%b want<300/1",
               n, clr_busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0) begin
      bad++;
      $display("FAIL abort_we got=%b want=0", mem_we);
    end
    step(); #1;
    total++;
    if ({clr_busy, clr_done} !== 2'b00) begin
      bad++;
      $display("FAIL abort_st got=%b want=00",
               {clr_busy, clr_done});
    end
    rst_n = 1'b1;
    last_b = 1'b1;
    step(); #1;
    total++;
    if ({clr_busy, clr_done} !== 2'b00) begin
      bad++;
      $display("FAIL abort_done got=%b want=00",
               {clr_busy, clr_done});
    end
    for (int i = 0; i < 100; i++) ref_mem[i] = 8'hC3;
    errs = 0;
    for (int i = 0; i < LEN; i++)
      if (bram[i] !== ref_mem[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL abort_image got=%0d want=0 bad words",
               errs);
    end
    step();
  endtask

  task automatic test_random();
    bit         pa, pb, ga, gb, eav, ebv, known;
    int         wa, wb;
    logic [7:0] ead, ebd, prev;
    pa = 0; pb = 0; wa = 0; wb = 0;
    eav = 0; ebv = 0; known = 0;
    ead = '0; ebd = '0; prev = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1; wa = 0;
        a_we = 1'($urandom_range(0, 1));
        a_addr = 8'($urandom_range(0, 15));
        a_wdata = 8'($urandom);
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1; wb = 0;
        b_we = 1'($urandom_range(0, 1));
        b_addr = 8'($urandom_range(0, 15));
        b_wdata = 8'($urandom);
      end
      a_req = pa; b_req = pb;
      #1;
      total++;
      if (a_rvalid !== eav || b_rvalid !== ebv ||
          (eav && a_rdata !== ead) ||
          (ebv && b_rdata !== ebd)) begin
        bad++;
        $display("FAIL rnd_rv c%0d got=%b%b/%h/%h want=%b%b/%h/%h",
                 c, a_rvalid, b_rvalid, a_rdata, b_rdata,
                 eav, ebv, ead, ebd);
      end
      ga = pa && (!pb || last_b);
      gb = pb && !ga;
      total++;
      if (a_gnt !== ga || b_gnt !== gb) begin
        bad++;
        $display("FAIL rnd_gnt c%0d got=%b%b want=%b%b",
                 c, a_gnt, b_gnt, ga, gb);
      end
      total++;
      if (ga) begin
        if (mem_addr !== a_addr || mem_we !== a_we ||
            (a_we && mem_din !== a_wdata)) begin
          bad++;
          $display("FAIL rnd_muxa c%0d got=%h/%b want=%h/%b",
                   c, mem_addr, mem_we, a_addr, a_we);
        end
      end else if (gb) begin
        if (mem_addr !== b_addr || mem_we !== b_we ||
            (b_we && mem_din !== b_wdata)) begin
          bad++;
          $display("FAIL rnd_muxb c%0d got=%h/%b want=%h/%b",
                   c, mem_addr, mem_we, b_addr, b_we);
        end
      end else if (mem_we !== 1'b0 ||
                   (known && mem_addr !== prev)) begin
        bad++;
        $display("FAIL rnd_hold c%0d got=%h/%b want=%h/0",
                 c, mem_addr, mem_we, prev);
      end
      eav = ga && !a_we;
      ebv = gb && !b_we;
      if (eav) ead = ref_mem[a_addr];
      if (ebv) ebd = ref_mem[b_addr];
      if (ga && a_we) ref_mem[a_addr] = a_wdata;
      if (gb && b_we) ref_mem[b_addr] = b_wdata;
      if (ga) begin prev = a_addr; known = 1; end
      if (gb) begin prev = b_addr; known = 1; end
      if (ga) begin pa = 0; last_b = 0; end
      else if (pa) wa++;
      if (gb) begin pb = 0; last_b = 1; end
      else if (pb) wb++;
      total++;
      if (wa > 1 || wb > 1) begin
        bad++;
        $display("FAIL rnd_wait c%0d got=%0d/%0d want<=1",
                 c, wa, wb);
      end
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < LEN; i++) begin
      bram[i] = 8'($urandom);
      ref_mem[i] = bram[i];
    end
    mem_dout = '0;
    last_b = 1'b1;
    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_clear(8'h20, 1'b0);
    test_clear(8'h7E, 1'b1);
    test_clear_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
